// File: rtl/player_physics.sv
// rtl/player_physics.sv - gravity-flip platformer player vertical physics.
// Define PLAYER_PHYSICS_ACCEL_EN for accelerating fall/rise; default build moves 1 pixel per tick.
module player_physics #(
    parameter int N_LINES    = 3,
    parameter int LINE_PITCH = 120,
    parameter int PLAYER_H   = 60,
    parameter int SCREEN_H   = 480,
    parameter int Y_W        = 9,
    parameter int VEL_W      = 3,
    parameter int VMAX       = 4,
    parameter int START_LINE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               flip_req,
    input  logic [N_LINES-1:0] lines,
    output logic [Y_W-1:0]     height,
    output logic               grav_dir,
    output logic               grounded,
    output logic [VEL_W-1:0]   vel,
    output logic               flip_ack,
    output logic               dead
);

    localparam logic [1:0] S_GROUNDED = 2'd0;
    localparam logic [1:0] S_AIRBORNE = 2'd1;
    localparam logic [1:0] S_DEAD     = 2'd2;

    localparam logic [Y_W:0]     L_FLOOR = (Y_W+1)'(SCREEN_H - PLAYER_H);
    localparam logic [Y_W-1:0]   L_START = Y_W'((START_LINE + 1) * LINE_PITCH - PLAYER_H);
    localparam logic [VEL_W-1:0] L_VMAX  = VEL_W'(VMAX);

    logic [1:0]       r_state;
    logic [Y_W-1:0]   r_height;
    logic             r_grav;
    logic [VEL_W-1:0] r_vel;
    logic             r_pending;
    logic             r_flip_ack;

    logic [VEL_W-1:0] w_vel_next;
    logic [Y_W:0]     w_h;
    logic [Y_W:0]     w_v;
    logic [Y_W:0]     w_hi;
    logic [Y_W:0]     w_lo;
    logic             w_up_dead;
    logic             w_flip;
    logic             w_supported;
    logic             w_hit;
    logic [Y_W:0]     w_hit_y;
    logic [Y_W:0]     w_land;

    // Surface the sprite's top-left sits on for line k, given gravity direction.
    function automatic logic [Y_W:0] land_y(input int k, input logic up);
        if (up)
            return (Y_W+1)'((k + 1) * LINE_PITCH);
        else
            return (Y_W+1)'((k + 1) * LINE_PITCH - PLAYER_H);
    endfunction

`ifdef PLAYER_PHYSICS_ACCEL_EN
    assign w_vel_next = (r_vel >= L_VMAX) ? L_VMAX : r_vel + VEL_W'(1);
`else
    assign w_vel_next = (L_VMAX == '0) ? '0 : VEL_W'(1);
`endif

    assign w_h       = {1'b0, r_height};
    assign w_v       = {{(Y_W+1-VEL_W){1'b0}}, w_vel_next};
    assign w_hi      = w_h + w_v;
    assign w_up_dead = (w_v > w_h);
    assign w_lo      = w_up_dead ? '0 : (w_h - w_v);
    assign w_flip    = r_pending | flip_req;

    // Nearest present line strictly ahead of the sprite and inside this tick's sweep.
    always_comb begin
        w_supported = 1'b0;
        w_hit       = 1'b0;
        w_hit_y     = w_h;
        w_land      = '0;
        for (int k = 0; k < N_LINES; k++) begin
            w_land = land_y(k, r_grav);
            if (lines[k]) begin
                if (w_land == w_h)
                    w_supported = 1'b1;
                if (!r_grav) begin
                    if (w_land > w_h && w_land <= w_hi && (!w_hit || w_land < w_hit_y)) begin
                        w_hit   = 1'b1;
                        w_hit_y = w_land;
                    end
                end else begin
                    if (w_land < w_h && w_land >= w_lo && (!w_hit || w_land > w_hit_y)) begin
                        w_hit   = 1'b1;
                        w_hit_y = w_land;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_GROUNDED;
            r_height   <= L_START;
            r_grav     <= 1'b0;
            r_vel      <= '0;
            r_pending  <= 1'b0;
            r_flip_ack <= 1'b0;
        end else begin
            r_flip_ack <= 1'b0;
            if (r_state != S_DEAD) begin
                if (tick) begin
                    r_pending <= 1'b0;
                    case (r_state)
                        S_GROUNDED: begin
                            if (w_flip) begin
                                r_grav     <= ~r_grav;
                                r_vel      <= '0;
                                r_state    <= S_AIRBORNE;
                                r_flip_ack <= 1'b1;
                            end else if (!w_supported) begin
                                r_vel   <= '0;
                                r_state <= S_AIRBORNE;
                            end
                        end
                        S_AIRBORNE: begin
                            if (w_hit) begin
                                r_height <= w_hit_y[Y_W-1:0];
                                r_vel    <= '0;
                                r_state  <= S_GROUNDED;
                            end else if (!r_grav && w_hi > L_FLOOR) begin
                                r_height <= L_FLOOR[Y_W-1:0];
                                r_vel    <= '0;
                                r_state  <= S_DEAD;
                            end else if (r_grav && w_up_dead) begin
                                r_height <= '0;
                                r_vel    <= '0;
                                r_state  <= S_DEAD;
                            end else begin
                                r_height <= r_grav ? w_lo[Y_W-1:0] : w_hi[Y_W-1:0];
                                r_vel    <= w_vel_next;
                            end
                        end
                        default: ;
                    endcase
                end else if (flip_req) begin
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign height   = r_height;
    assign grav_dir = r_grav;
    assign grounded = (r_state == S_GROUNDED);
    assign dead     = (r_state == S_DEAD);
    assign vel      = r_vel;
    assign flip_ack = r_flip_ack;

endmodule

// File: tb/tb_player_physics.sv
// tb/tb_player_physics.sv - scoreboard bench for player_physics (expectations follow PLAYER_PHYSICS_ACCEL_EN).
module tb_player_physics;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       flip_req = 1'b0;
    logic [2:0] lines = 3'b000;
    logic [8:0] height;
    logic       grav_dir;
    logic       grounded;
    logic [2:0] vel;
    logic       flip_ack;
    logic       dead;

    logic       obs = 1'b0;
    logic       r_obs_d = 1'b0;

    typedef struct packed {
        logic [8:0] h;
        logic       gnd;
        logic       gd;
        logic       dd;
        logic [2:0] v;
        logic       fa;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_exp;
    exp_t m_act;
    int   n_vec = 0;
    int   n_miss = 0;

    player_physics dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .flip_req (flip_req),
        .lines    (lines),
        .height   (height),
        .grav_dir (grav_dir),
        .grounded (grounded),
        .vel      (vel),
        .flip_ack (flip_ack),
        .dead     (dead)
    );

    always #5 clk = ~clk;

    always @(posedge clk) r_obs_d <= obs;

    always @(negedge clk) begin
        if (r_obs_d) begin
            m_act = {height, grounded, grav_dir, dead, vel, flip_ack};
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL vec%0d unexpected output h=%0d gnd=%0d gd=%0d dead=%0d vel=%0d ack=%0d, required none",
                         n_vec, height, grounded, grav_dir, dead, vel, flip_ack);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp) begin
                    n_miss++;
                    $display("FAIL vec%0d state got h=%0d gnd=%0d gd=%0d dead=%0d vel=%0d ack=%0d want h=%0d gnd=%0d gd=%0d dead=%0d vel=%0d ack=%0d",
                             n_vec, m_act.h, m_act.gnd, m_act.gd, m_act.dd, m_act.v, m_act.fa,
                             m_exp.h, m_exp.gnd, m_exp.gd, m_exp.dd, m_exp.v, m_exp.fa);
                end
            end
            n_vec++;
        end
    end

    function automatic int vstep(input int i);
`ifdef PLAYER_PHYSICS_ACCEL_EN
        return (i > 4) ? 4 : i;
`else
        return 1;
`endif
    endfunction

    task automatic push(input int h, input bit g, input bit gd, input bit dd, input int v, input bit fa);
        exp_t e;
        e.h   = 9'(h);
        e.gnd = g;
        e.gd  = gd;
        e.dd  = dd;
        e.v   = 3'(v);
        e.fa  = fa;
        exp_q.push_back(e);
    endtask

    task automatic tk(input int h, input bit g, input bit gd, input bit dd, input int v, input bit fa);
        push(h, g, gd, dd, v, fa);
        tick = 1'b1;
        obs  = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        obs  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rst(input bit with_tick);
        push(180, 1, 0, 0, 0, 0);
        reset    = 1'b1;
        tick     = with_tick;
        flip_req = with_tick;
        obs      = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        tick     = 1'b0;
        flip_req = 1'b0;
        obs      = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic flip_pulse();
        flip_req = 1'b1;
        @(posedge clk); #1;
        flip_req = 1'b0;
    endtask

    initial begin
        int h;
        int v;
        @(posedge clk); #1;

        // Standing on line 1
        rst(0);
        lines = 3'b010;
        repeat (10) tk(180, 1, 0, 0, 0, 0);

        // Fall from line 1 to line 2 (surface 360 -> top 300)
        rst(0);
        lines = 3'b100;
        tk(180, 0, 0, 0, 0, 0);
        h = 180;
        for (int i = 1; i < 400; i++) begin
            v = vstep(i);
            if (h + v >= 300) begin
                tk(300, 1, 0, 0, 0, 0);
                break;
            end
            h += v;
            tk(h, 0, 0, 0, v, 0);
        end
        repeat (2) tk(300, 1, 0, 0, 0, 0);

        // Flip up to line 0, with a dropped request mid-flight
        rst(0);
        lines = 3'b011;
        flip_pulse();
        tk(180, 0, 1, 0, 0, 1);
        h = 180;
        for (int i = 1; i < 400; i++) begin
            v = vstep(i);
            if (i == 3) flip_pulse();
            if (h - v <= 120) begin
                tk(120, 1, 1, 0, 0, 0);
                break;
            end
            h -= v;
            tk(h, 0, 1, 0, v, 0);
        end
        repeat (2) tk(120, 1, 1, 0, 0, 0);

        // Fall off the bottom, then DEAD ignores everything until reset
        rst(0);
        lines = 3'b000;
        tk(180, 0, 0, 0, 0, 0);
        h = 180;
        for (int i = 1; i < 600; i++) begin
            v = vstep(i);
            if (h + v > 420) begin
                tk(420, 0, 0, 1, 0, 0);
                break;
            end
            h += v;
            tk(h, 0, 0, 0, v, 0);
        end
        flip_pulse();
        lines = 3'b111;
        repeat (3) tk(420, 0, 0, 1, 0, 0);
        rst(0);

        // Flip off the top of the screen
        lines = 3'b000;
        flip_pulse();
        tk(180, 0, 1, 0, 0, 1);
        h = 180;
        for (int i = 1; i < 600; i++) begin
            v = vstep(i);
            if (v > h) begin
                tk(0, 0, 1, 1, 0, 0);
                break;
            end
            h -= v;
            tk(h, 0, 1, 0, v, 0);
        end

        // No tick for 50 cycles: nothing moves
        rst(0);
        lines = 3'b000;
        repeat (50) @(posedge clk);
        #1;
        push(180, 1, 0, 0, 0, 0);
        obs = 1'b1;
        @(posedge clk); #1;
        obs = 1'b0;
        @(posedge clk); #1;

        // Reset wins over tick and flip mid-fall
        tk(180, 0, 0, 0, 0, 0);
        tk(181, 0, 0, 0, 1, 0);
        rst(1);
        tk(180, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/player_physics.md
PLAYER_PHYSICS -- requirements
Module: player_physics

Interface
REQ-001 SHALL have parameter N_LINES, default 3, number of horizontal platform lines.
REQ-002 SHALL have parameter LINE_PITCH, default 120, pixel spacing; line k surface at y=(k+1)*LINE_PITCH.
REQ-003 SHALL have parameter PLAYER_H, default 60, player sprite height in pixels.
REQ-004 SHALL have parameter SCREEN_H, default 480, playfield height in pixels.
REQ-005 SHALL have parameter Y_W, default 9, width of height output.
REQ-006 SHALL have parameter VEL_W, default 3, and VMAX, default 4 (VMAX <= 2^VEL_W-1), maximum pixels per tick.
REQ-007 SHALL have parameter START_LINE, default 1, line the player stands on at reset.
REQ-008 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-010 SHALL have port tick  input  1  one-cycle motion step enable (one per frame).
REQ-011 SHALL have port flip_req  input  1  gravity flip request pulse, any cycle.
REQ-012 SHALL have port lines  input  N_LINES  lines[k]=1: line k exists at player x.
REQ-013 SHALL have port height  output  Y_W  y of player top-left (0 = screen top).
REQ-014 SHALL have ports grav_dir  output  1  (0 down, 1 up); grounded  output  1; vel  output  VEL_W  current speed magnitude.
REQ-015 SHALL have ports flip_ack  output  1  one-cycle flip accepted pulse; dead  output  1  sticky off-screen flag.

Function
REQ-016 SHALL implement states GROUNDED, AIRBORNE, DEAD; grounded=1 only in GROUNDED; dead=1 only in DEAD.
REQ-017 SHALL change height, vel, grav_dir and state only on cycles with tick=1, except flip_req latching.
REQ-018 SHALL latch flip_req into a pending bit; on tick, GROUNDED with pending: toggle grav_dir, vel=0, go AIRBORNE, pulse flip_ack next cycle, no movement that tick.
REQ-019 SHALL clear pending on every tick; requests arriving while AIRBORNE or DEAD are dropped without flip_ack.
REQ-020 SHALL, GROUNDED with no flip, hold height if supporting line still present; else go AIRBORNE with vel=0, no movement that tick.
REQ-021 SHALL, AIRBORNE on tick, set vel=min(vel+1,VMAX), then move height by new vel (down: +, up: -).
REQ-022 SHALL define landing y for line k: down (k+1)*LINE_PITCH-PLAYER_H, up (k+1)*LINE_PITCH; a line is a landing candidate only if lines[k]=1.
REQ-023 SHALL, when any candidate lies strictly beyond current height and within the swept step, snap height to the nearest such candidate, vel=0, go GROUNDED.
REQ-024 SHALL, when down step exceeds SCREEN_H-PLAYER_H, clamp height there; when up step exceeds current height, clamp to 0; either case go DEAD, vel=0.
REQ-025 SHALL compute step arithmetic in Y_W+1 bits, with no wrap-around.
REQ-026 SHALL ignore tick and flip_req in DEAD until reset.

Reset
REQ-027 SHALL, on clk edge with reset=1, set height=(START_LINE+1)*LINE_PITCH-PLAYER_H (180 default), grav_dir=0, state GROUNDED, vel=0, pending=0, flip_ack=0, dead=0.
REQ-028 SHALL give reset priority over tick and flip_req in the same cycle, including mid-fall.

Configuration
REQ-029 SHALL, with macro PLAYER_PHYSICS_ACCEL_EN defined, use the accelerating velocity of REQ-021.
REQ-030 SHALL, without PLAYER_PHYSICS_ACCEL_EN, move AIRBORNE at constant 1 pixel per tick (vel reads 1 AIRBORNE, 0 otherwise); all other rules unchanged.

Verification (defaults, ACCEL_EN defined)
REQ-031 SHALL test: reset, lines=3'b010, 10 ticks -> height 180, grounded=1, grav_dir=0 throughout.
REQ-032 SHALL test: lines=3'b100 from reset, ticks -> AIRBORNE, heights 180,181,183,186,190,194..298, then snap 300, grounded=1, vel=0.
REQ-033 SHALL test: at 180 lines=3'b011, flip_req + tick -> flip_ack 1 cycle, grav_dir=1; then 179,177,174,170..122, snap 120, grounded.
REQ-034 SHALL test: flip_req while AIRBORNE -> no flip_ack, grav_dir unchanged, pending cleared at next tick.
REQ-035 SHALL test: lines=3'b000 from reset, ticks -> height clamps 420, dead=1; further ticks/flip no change; reset -> 180, dead=0.
REQ-036 SHALL test: tick held 0 with lines=3'b000 for 50 cycles -> height 180, state unchanged.
